// File: rtl/cmp_serial_multibit.sv
// Sequential magnitude comparator: walks two WIDTH-bit operands MSB-first, CHUNK bits per
// clock, stopping at the first differing chunk; start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outcome registers hold the last result
// SCAN  | comparing one chunk pair per clock, MSB chunk first
module cmp_serial_multibit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    input  logic             signed_en,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    localparam logic [2:0] MODE_GE = 3'd0;
    localparam logic [2:0] MODE_GT = 3'd1;
    localparam logic [2:0] MODE_LT = 3'd2;
    localparam logic [2:0] MODE_LE = 3'd3;
    localparam logic [2:0] MODE_EQ = 3'd4;
    localparam logic [2:0] MODE_NE = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       mode_q;
    logic             signed_q;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] ca, cb;
    logic             chunk_gt, chunk_lt, chunk_ne, last, finish, res_nxt;

    // Operands shift left each step, so the chunk under test is always the top CHUNK bits.
    always_comb begin
        ca = a_q[WIDTH-1 -: CHUNK];
        cb = b_q[WIDTH-1 -: CHUNK];
        if (signed_q && (idx == '0)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
        chunk_gt = (ca > cb);
        chunk_lt = (ca < cb);
        chunk_ne = (ca != cb);
        last     = (idx == LAST);
        finish   = chunk_ne || last;
    end

    always_comb begin
        res_nxt = 1'b0;
        case (mode_q)
            MODE_GE: res_nxt = !chunk_lt;
            MODE_GT: res_nxt = chunk_gt;
            MODE_LT: res_nxt = chunk_lt;
            MODE_LE: res_nxt = !chunk_gt;
            MODE_EQ: res_nxt = !chunk_ne;
            MODE_NE: res_nxt = chunk_ne;
            default: res_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)  state_nxt = SCAN;
            SCAN:    if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SCAN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= '0;
            signed_q <= 1'b0;
            idx      <= '0;
            done     <= 1'b0;
            result   <= 1'b0;
            gt       <= 1'b0;
            eq       <= 1'b0;
            lt       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_q      <= a;
                    b_q      <= b;
                    mode_q   <= mode;
                    signed_q <= signed_en;
                    idx      <= '0;
                end
            end else if (finish) begin
                done   <= 1'b1;
                result <= res_nxt;
                gt     <= chunk_gt;
                eq     <= !chunk_ne;
                lt     <= chunk_lt;
            end else begin
                idx <= idx + IW'(1);
                a_q <= a_q << CHUNK;
                b_q <= b_q << CHUNK;
            end
        end
    end

endmodule
